// File: rtl/table_state_reporter_if.sv
// Bus bundle for table_state_reporter: request/scan control, RAM port-B read
// path and the outgoing byte stream. The reporter is the master side.
interface table_state_reporter_if;
    logic       req_valid;
    logic [4:0] req_machine;
    logic       req_ready;
    logic       scan_start;
    logic       scan_done;
    logic [6:0] ram_addr;
    logic [8:0] ram_dout;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

    modport master (
        input  req_valid, req_machine, scan_start, ram_dout, tx_ready,
        output req_ready, scan_done, ram_addr, tx_data, tx_valid, busy
    );

    modport slave (
        output req_valid, req_machine, scan_start, ram_dout, tx_ready,
        input  req_ready, scan_done, ram_addr, tx_data, tx_valid, busy
    );
endinterface

// File: rtl/table_state_reporter.sv
// table_state_reporter: reads per-machine table words from the kitchen-state
// RAM (read-only port B) and serializes them into 5-byte frames, either for a
// single requested machine or for every machine in TABLE_MASK (scan).
// Optional feature macro: REPORT_CHECKSUM_EN appends an XOR checksum byte B5.
module table_state_reporter #(
    parameter logic [31:0] TABLE_MASK     = 32'h000A4A00,
    parameter int          RAM_STORE_SIZE = 4
) (
    input logic                    clk,
    input logic                    rst,
    table_state_reporter_if.master bus
);
`ifdef REPORT_CHECKSUM_EN
    localparam int NBYTES = 6;
`else
    localparam int NBYTES = 5;
`endif
    localparam logic [2:0] LAST_BYTE = 3'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, READ, SEND, NEXT} state_t;

    state_t                  r_state, w_state_nxt;
    logic                    r_scan;
    logic                    r_scan_done;
    logic [4:0]              r_machine;
    logic [6:0]              r_ram_addr;
    logic [2:0]              r_k;          // READ cycle index 0..4
    logic [2:0]              r_b;          // byte index within frame
    logic [8:0]              r_cnt_word;
    logic [2:0][5:0]         r_slot;

    logic                    w_first_vld, w_nxt_vld;
    logic [4:0]              w_first, w_nxt;
    logic                    w_req_ready, w_fire, w_err;
    logic [1:0]              w_cnt;
    logic [NBYTES-1:0][7:0]  w_frame;

    function automatic logic [6:0] base_addr(input logic [4:0] m);
        return 7'(int'(m) * RAM_STORE_SIZE);
    endfunction

    assign w_req_ready     = (r_state == IDLE) && !r_scan;
    assign w_fire          = (r_state == SEND) && bus.tx_ready;
    assign bus.req_ready   = w_req_ready;
    assign bus.busy        = (r_state != IDLE);
    assign bus.scan_done   = r_scan_done;
    assign bus.ram_addr    = r_ram_addr;
    assign bus.tx_valid    = (r_state == SEND);
    assign bus.tx_data     = (r_state == SEND) ? w_frame[r_b] : 8'h00;

    // Lowest masked machine overall, and lowest masked machine above the current one.
    always_comb begin
        w_first_vld = 1'b0;
        w_first     = 5'd0;
        w_nxt_vld   = 1'b0;
        w_nxt       = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (TABLE_MASK[i]) begin
                w_first_vld = 1'b1;
                w_first     = 5'(i);
                if (5'(i) > r_machine) begin
                    w_nxt_vld = 1'b1;
                    w_nxt     = 5'(i);
                end
            end
        end
    end

    // Frame assembly; counts above 3 are clamped and flagged, slots beyond the count read as 0.
    always_comb begin
        w_err      = (r_cnt_word > 9'd3);
        w_cnt      = w_err ? 2'd3 : r_cnt_word[1:0];
        w_frame    = '0;
        w_frame[0] = {3'b101, r_machine};
        w_frame[1] = {w_err, 4'b0000, 1'b0, w_cnt};
        for (int j = 1; j <= 3; j++) begin
            if (j <= int'(w_cnt)) w_frame[j+1] = {2'b00, r_slot[j-1]};
        end
`ifdef REPORT_CHECKSUM_EN
        w_frame[5] = w_frame[0] ^ w_frame[1] ^ w_frame[2] ^ w_frame[3] ^ w_frame[4];
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; scan_start wins over a simultaneous request.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.scan_start) begin
                    if (w_first_vld) w_state_nxt = READ;
                end else if (bus.req_valid && w_req_ready) begin
                    w_state_nxt = READ;
                end
            end
            READ:    if (r_k == 3'd4) w_state_nxt = SEND;
            SEND:    if (w_fire && r_b == LAST_BYTE) w_state_nxt = NEXT;
            NEXT:    w_state_nxt = (r_scan && w_nxt_vld) ? READ : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: machine latch, RAM address walk, word capture (one-cycle RAM latency), byte index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan      <= 1'b0;
            r_scan_done <= 1'b0;
            r_machine   <= 5'd0;
            r_ram_addr  <= 7'd0;
            r_k         <= 3'd0;
            r_b         <= 3'd0;
            r_cnt_word  <= 9'd0;
            r_slot      <= '0;
        end else begin
            r_scan_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_k <= 3'd0;
                    r_b <= 3'd0;
                    if (bus.scan_start) begin
                        if (w_first_vld) begin
                            r_scan     <= 1'b1;
                            r_machine  <= w_first;
                            r_ram_addr <= base_addr(w_first);
                        end else begin
                            r_scan_done <= 1'b1;
                        end
                    end else if (bus.req_valid && w_req_ready) begin
                        r_machine  <= bus.req_machine;
                        r_ram_addr <= base_addr(bus.req_machine);
                    end
                end
                READ: begin
                    if (r_k == 3'd1)      r_cnt_word <= bus.ram_dout;
                    else if (r_k >= 3'd2) r_slot[2'(r_k - 3'd2)] <= bus.ram_dout[5:0];
                    if (r_k < 3'd3) r_ram_addr <= r_ram_addr + 7'd1;
                    r_k <= r_k + 3'd1;
                    r_b <= 3'd0;
                end
                SEND: begin
                    if (w_fire) r_b <= r_b + 3'd1;
                end
                NEXT: begin
                    r_k <= 3'd0;
                    r_b <= 3'd0;
                    if (r_scan && w_nxt_vld) begin
                        r_machine  <= w_nxt;
                        r_ram_addr <= base_addr(w_nxt);
                    end else begin
                        r_scan      <= 1'b0;
                        r_scan_done <= r_scan;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
